time_counter_set: RTL and testbench

Parametrised successor to the 24-hour H:M:S digital-clock counter. Adds up/down counting, a 12/24-hour display mode, and a time-set mode with per-field adjust buttons. It contains the one-second prescaler and the BCD H:M:S register file. Its outputs feed the 7-segment scan/LED block.

---
 rtl/time_counter_set_pkg.sv | 37 +++
 rtl/time_counter_set_bcd_digit_updown.sv | 35 +++
 rtl/time_counter_set.sv | 101 ++++++++++
 tb/tb_time_counter_set.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/time_counter_set_pkg.sv
// Shared constants, field-select encodings and the 12-hour display map
// for the H:M:S counter.
package time_counter_set_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'b00,
    SEL_MIN  = 2'b01,
    SEL_HOUR = 2'b10,
    SEL_NONE = 2'b11
  } set_sel_e;

  // Map a BCD 24-hour value to its 12-hour display form, returned as {tens, ones}.
  function automatic logic [5:0] hour_to_12h(input logic [1:0] tens, input logic [3:0] ones);
    logic [5:0] hr;
    hr = {tens, ones};
    case (hr)
      6'h00:   return 6'h12;
      6'h13:   return 6'h01;
      6'h14:   return 6'h02;
      6'h15:   return 6'h03;
      6'h16:   return 6'h04;
      6'h17:   return 6'h05;
      6'h18:   return 6'h06;
      6'h19:   return 6'h07;
      6'h20:   return 6'h08;
      6'h21:   return 6'h09;
      6'h22:   return 6'h10;
      6'h23:   return 6'h11;
      default: return hr;
    endcase
  endfunction

endpackage

// File: rtl/time_counter_set_bcd_digit_updown.sv
// One BCD digit that counts up or down between 0 and MAX_DIGIT, with a
// parallel load and combinational carry/borrow for cascading.
module bcd_digit_updown #(
  parameter int MAX_DIGIT = 9,
  parameter int W         = $clog2(MAX_DIGIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] digit,
  output logic         carry,
  output logic         borrow
);

  localparam logic [W-1:0] DMAX = W'(MAX_DIGIT);

  assign carry  = en && !dir && (digit == DMAX);
  assign borrow = en &&  dir && (digit == '0);

  // Load wins over counting; counting wraps inside 0..MAX_DIGIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (en) begin
      if (dir) digit <= (digit == '0)  ? DMAX : digit - 1'b1;
      else     digit <= (digit == DMAX) ? '0  : digit + 1'b1;
    end
  end

endmodule

// File: rtl/time_counter_set.sv
// Up/down 24-hour BCD clock with one-second prescaler, time-set mode and
// 12/24-hour hour display.
module time_counter_set
  import time_counter_set_pkg::*;
#(
  parameter int SEC1_MAX = 100000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DEC,
  input  logic       MODE12,
  input  logic       SET_EN,
  input  logic [1:0] SET_SEL,
  input  logic       INC_BTN,
  input  logic       DEC_BTN,
  output logic       ENABLE,
  output logic [3:0] SEC_ONES,
  output logic [2:0] SEC_TENS,
  output logic [3:0] MIN_ONES,
  output logic [2:0] MIN_TENS,
  output logic [3:0] HOUR_ONES,
  output logic [1:0] HOUR_TENS,
  output logic       PM,
  output logic       DAY_TICK
);

  localparam int             PW         = $clog2(SEC1_MAX);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(SEC1_MAX - 1);
  localparam logic [1:0]     HOUR_TMAX  = 2'(HOUR_MAX / 10);
  localparam logic [3:0]     HOUR_OMAX  = 4'(HOUR_MAX % 10);

  logic [PW-1:0] presc;
  logic          adj, dir;
  logic          sel_sec, sel_min, sel_hour;
  logic          so_c, so_b, st_c, st_b, mo_c, mo_b, mt_c, mt_b, ho_c, ho_b, ht_c, ht_b;
  logic          sec_tens_en, min_ones_en, min_tens_en, hour_ones_en, hour_tens_en;
  logic          hour_up_wrap, hour_load;
  logic [1:0]    hour_tens, hour_load_tens;
  logic [3:0]    hour_ones, hour_load_ones;

  // A pending tick has priority; buttons only act in set mode when exactly one is pressed.
  assign adj      = SET_EN && !ENABLE && (INC_BTN ^ DEC_BTN);
  assign dir      = ENABLE ? DEC : DEC_BTN;
  assign sel_sec  = adj && (SET_SEL == SEL_SEC);
  assign sel_min  = adj && (SET_SEL == SEL_MIN);
  assign sel_hour = adj && (SET_SEL == SEL_HOUR);

  assign sec_tens_en  = so_c | so_b;
  assign min_ones_en  = (ENABLE && (st_c | st_b)) | sel_min;
  assign min_tens_en  = mo_c | mo_b;
  assign hour_ones_en = (ENABLE && (mt_c | mt_b)) | sel_hour;
  assign hour_tens_en = ho_c | ho_b;

  // Hours wrap at 23 across both digits, so the wrap is forced with a load.
  assign hour_up_wrap   = hour_ones_en && !dir && (hour_tens == HOUR_TMAX) && (hour_ones == HOUR_OMAX);
  assign hour_load      = hour_up_wrap | ht_c | ht_b;
  assign hour_load_tens = ht_b ? HOUR_TMAX : 2'd0;
  assign hour_load_ones = ht_b ? HOUR_OMAX : 4'd0;

  // Prescaler, registered second tick and day-wrap pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      presc    <= '0;
      ENABLE   <= 1'b0;
      DAY_TICK <= 1'b0;
    end else begin
      ENABLE   <= !SET_EN && (presc == PRESC_LAST);
      DAY_TICK <= ENABLE && !SET_EN && (hour_up_wrap | ht_b);
      if (SET_EN || presc == PRESC_LAST) presc <= '0;
      else                               presc <= presc + 1'b1;
    end
  end

  bcd_digit_updown #(.MAX_DIGIT(9)) u_sec_ones (
    .clk(CLK), .rst_n(RESET), .en(ENABLE | sel_sec), .dir(dir), .load(1'b0), .load_val(4'd0),
    .digit(SEC_ONES), .carry(so_c), .borrow(so_b));

  bcd_digit_updown #(.MAX_DIGIT(SEC_MAX / 10)) u_sec_tens (
    .clk(CLK), .rst_n(RESET), .en(sec_tens_en), .dir(dir), .load(1'b0), .load_val(3'd0),
    .digit(SEC_TENS), .carry(st_c), .borrow(st_b));

  bcd_digit_updown #(.MAX_DIGIT(9)) u_min_ones (
    .clk(CLK), .rst_n(RESET), .en(min_ones_en), .dir(dir), .load(1'b0), .load_val(4'd0),
    .digit(MIN_ONES), .carry(mo_c), .borrow(mo_b));

  bcd_digit_updown #(.MAX_DIGIT(MIN_MAX / 10)) u_min_tens (
    .clk(CLK), .rst_n(RESET), .en(min_tens_en), .dir(dir), .load(1'b0), .load_val(3'd0),
    .digit(MIN_TENS), .carry(mt_c), .borrow(mt_b));

  bcd_digit_updown #(.MAX_DIGIT(9)) u_hour_ones (
    .clk(CLK), .rst_n(RESET), .en(hour_ones_en), .dir(dir), .load(hour_load), .load_val(hour_load_ones),
    .digit(hour_ones), .carry(ho_c), .borrow(ho_b));

  bcd_digit_updown #(.MAX_DIGIT(HOUR_MAX / 10)) u_hour_tens (
    .clk(CLK), .rst_n(RESET), .en(hour_tens_en), .dir(dir), .load(hour_load), .load_val(hour_load_tens),
    .digit(hour_tens), .carry(ht_c), .borrow(ht_b));

  assign {HOUR_TENS, HOUR_ONES} = MODE12 ? hour_to_12h(hour_tens, hour_ones) : {hour_tens, hour_ones};
  assign PM = (hour_tens > 2'd1) || ((hour_tens == 2'd1) && (hour_ones >= 4'd2));

endmodule

// File: tb/tb_time_counter_set.sv
// Directed self-checking bench for time_counter_set with a 4-cycle second.
module tb_time_counter_set;
  import time_counter_set_pkg::*;

  localparam int SEC1_MAX = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       DEC = 1'b0;
  logic       MODE12 = 1'b0;
  logic       SET_EN = 1'b0;
  logic [1:0] SET_SEL = 2'b11;
  logic       INC_BTN = 1'b0;
  logic       DEC_BTN = 1'b0;
  logic       ENABLE, PM, DAY_TICK;
  logic [3:0] SEC_ONES, MIN_ONES, HOUR_ONES;
  logic [2:0] SEC_TENS, MIN_TENS;
  logic [1:0] HOUR_TENS;

  int tests_run = 0;
  int tests_failed = 0;

  time_counter_set #(.SEC1_MAX(SEC1_MAX)) dut (
    .CLK(CLK), .RESET(RESET), .DEC(DEC), .MODE12(MODE12), .SET_EN(SET_EN),
    .SET_SEL(SET_SEL), .INC_BTN(INC_BTN), .DEC_BTN(DEC_BTN), .ENABLE(ENABLE),
    .SEC_ONES(SEC_ONES), .SEC_TENS(SEC_TENS), .MIN_ONES(MIN_ONES), .MIN_TENS(MIN_TENS),
    .HOUR_ONES(HOUR_ONES), .HOUR_TENS(HOUR_TENS), .PM(PM), .DAY_TICK(DAY_TICK));

  always #5 CLK = ~CLK;

  wire [19:0] disp = {HOUR_TENS, HOUR_ONES, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};
  wire [5:0]  hour = {HOUR_TENS, HOUR_ONES};

  function automatic logic [19:0] hms(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset(input logic set_en, input logic dec, input logic mode12);
    @(negedge CLK);
    RESET = 1'b0; SET_EN = set_en; DEC = dec; MODE12 = mode12;
    SET_SEL = SEL_NONE; INC_BTN = 1'b0; DEC_BTN = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic pulse(input logic inc, input logic dec, input logic [1:0] sel, input int n);
    repeat (n) begin
      SET_SEL = sel; INC_BTN = inc; DEC_BTN = dec;
      @(negedge CLK);
      INC_BTN = 1'b0; DEC_BTN = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2 RESET = 1'b0;
    #1;
    tests_run++; if (disp !== 20'h0) begin tests_failed++; $display("[TB] FAIL reset_time got %h want %h", disp, 20'h0); end
    tests_run++; if ({ENABLE, DAY_TICK, PM} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags got %b want 000", {ENABLE, DAY_TICK, PM}); end
    MODE12 = 1'b1; #1;
    tests_run++; if ({hour, PM} !== {6'h12, 1'b0}) begin tests_failed++; $display("[TB] FAIL reset_12h got %h pm %b want 12 pm 0", hour, PM); end
  endtask

  task automatic test_count_up;
    do_reset(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      tests_run++; if (ENABLE !== (k % 4 == 0)) begin tests_failed++; $display("[TB] FAIL enable_cycle%0d got %b want %b", k, ENABLE, (k % 4 == 0)); end
    end
    step(41 - 12);
    tests_run++; if (disp !== hms(0, 0, 10)) begin tests_failed++; $display("[TB] FAIL up_10s got %h want %h", disp, hms(0, 0, 10)); end
    step(241 - 41);
    tests_run++; if (disp !== hms(0, 1, 0)) begin tests_failed++; $display("[TB] FAIL up_60s got %h want %h", disp, hms(0, 1, 0)); end
    step(14401 - 241);
    tests_run++; if (disp !== hms(1, 0, 0)) begin tests_failed++; $display("[TB] FAIL up_3600s got %h want %h", disp, hms(1, 0, 0)); end
    tests_run++; if (DAY_TICK !== 1'b0) begin tests_failed++; $display("[TB] FAIL up_daytick got %b want 0", DAY_TICK); end
  endtask

  task automatic test_day_wrap_up;
    do_reset(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, SEL_HOUR, 1);
    tests_run++; if (disp !== hms(23, 0, 0)) begin tests_failed++; $display("[TB] FAIL set_hour_dec got %h want %h", disp, hms(23, 0, 0)); end
    pulse(1'b0, 1'b1, SEL_MIN, 1);
    pulse(1'b0, 1'b1, SEL_SEC, 1);
    tests_run++; if (disp !== hms(23, 59, 59)) begin tests_failed++; $display("[TB] FAIL set_235959 got %h want %h", disp, hms(23, 59, 59)); end
    SET_SEL = SEL_NONE; SET_EN = 1'b0;
    step(4);
    tests_run++; if ({ENABLE, disp} !== {1'b1, hms(23, 59, 59)}) begin tests_failed++; $display("[TB] FAIL exit_set_enable got en %b time %h want en 1 time %h", ENABLE, disp, hms(23, 59, 59)); end
    step(1);
    tests_run++; if ({DAY_TICK, disp} !== {1'b1, hms(0, 0, 0)}) begin tests_failed++; $display("[TB] FAIL wrap_up got tick %b time %h want tick 1 time 0", DAY_TICK, disp); end
    step(1);
    tests_run++; if (DAY_TICK !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_up_once got %b want 0", DAY_TICK); end
  endtask

  task automatic test_day_wrap_down;
    do_reset(1'b0, 1'b1, 1'b0);
    step(5);
    tests_run++; if ({DAY_TICK, disp} !== {1'b1, hms(23, 59, 59)}) begin tests_failed++; $display("[TB] FAIL wrap_down got tick %b time %h want tick 1 time %h", DAY_TICK, disp, hms(23, 59, 59)); end
    step(1);
    tests_run++; if (DAY_TICK !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_down_once got %b want 0", DAY_TICK); end
    step(3);
    tests_run++; if ({DAY_TICK, disp} !== {1'b0, hms(23, 59, 58)}) begin tests_failed++; $display("[TB] FAIL down_second got tick %b time %h want tick 0 time %h", DAY_TICK, disp, hms(23, 59, 58)); end
  endtask

  task automatic test_mode12;
    do_reset(1'b1, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, SEL_SEC, 1);
    pulse(1'b1, 1'b0, SEL_MIN, 2);
    tests_run++; if ({hour, PM} !== {6'h12, 1'b0}) begin tests_failed++; $display("[TB] FAIL h12_00 got %h pm %b want 12 pm 0", hour, PM); end
    pulse(1'b1, 1'b0, SEL_HOUR, 12);
    tests_run++; if ({hour, PM} !== {6'h12, 1'b1}) begin tests_failed++; $display("[TB] FAIL h12_12 got %h pm %b want 12 pm 1", hour, PM); end
    pulse(1'b1, 1'b0, SEL_HOUR, 1);
    tests_run++; if ({hour, PM} !== {6'h01, 1'b1}) begin tests_failed++; $display("[TB] FAIL h12_13 got %h pm %b want 01 pm 1", hour, PM); end
    pulse(1'b1, 1'b0, SEL_HOUR, 10);
    tests_run++; if ({hour, PM} !== {6'h11, 1'b1}) begin tests_failed++; $display("[TB] FAIL h12_23 got %h pm %b want 11 pm 1", hour, PM); end
    MODE12 = 1'b0; #1;
    tests_run++; if ({PM, disp} !== {1'b1, hms(23, 2, 1)}) begin tests_failed++; $display("[TB] FAIL h24_switch got pm %b time %h want pm 1 time %h", PM, disp, hms(23, 2, 1)); end
  endtask

  task automatic test_set_fields;
    do_reset(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, SEL_HOUR, 10);
    pulse(1'b0, 1'b1, SEL_MIN, 1);
    pulse(1'b1, 1'b0, SEL_SEC, 30);
    tests_run++; if (disp !== hms(10, 59, 30)) begin tests_failed++; $display("[TB] FAIL set_105930 got %h want %h", disp, hms(10, 59, 30)); end
    pulse(1'b1, 1'b0, SEL_MIN, 1);
    tests_run++; if (disp !== hms(10, 0, 30)) begin tests_failed++; $display("[TB] FAIL min_wrap_nocarry got %h want %h", disp, hms(10, 0, 30)); end
    pulse(1'b1, 1'b1, SEL_MIN, 1);
    tests_run++; if (disp !== hms(10, 0, 30)) begin tests_failed++; $display("[TB] FAIL both_buttons got %h want %h", disp, hms(10, 0, 30)); end
    pulse(1'b1, 1'b0, SEL_NONE, 1);
    tests_run++; if (disp !== hms(10, 0, 30)) begin tests_failed++; $display("[TB] FAIL sel_none got %h want %h", disp, hms(10, 0, 30)); end
    pulse(1'b0, 1'b1, SEL_HOUR, 1);
    tests_run++; if (disp !== hms(9, 0, 30)) begin tests_failed++; $display("[TB] FAIL hour_borrow got %h want %h", disp, hms(9, 0, 30)); end
    tests_run++; if ({ENABLE, DAY_TICK} !== 2'b00) begin tests_failed++; $display("[TB] FAIL set_no_tick got %b want 00", {ENABLE, DAY_TICK}); end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, SEL_HOUR, 5);
    pulse(1'b1, 1'b0, SEL_MIN, 12);
    pulse(1'b1, 1'b0, SEL_SEC, 34);
    SET_SEL = SEL_NONE; SET_EN = 1'b0;
    step(5);
    tests_run++; if (disp !== hms(5, 12, 35)) begin tests_failed++; $display("[TB] FAIL run_051235 got %h want %h", disp, hms(5, 12, 35)); end
    step(3);
    tests_run++; if (ENABLE !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset_enable got %b want 1", ENABLE); end
    #2 RESET = 1'b0;
    #1;
    tests_run++; if ({ENABLE, DAY_TICK, disp} !== 22'h0) begin tests_failed++; $display("[TB] FAIL mid_reset got en %b tick %b time %h want all 0", ENABLE, DAY_TICK, disp); end
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      tests_run++; if (ENABLE !== (k == 4)) begin tests_failed++; $display("[TB] FAIL post_reset_enable%0d got %b want %b", k, ENABLE, (k == 4)); end
    end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_day_wrap_up;
    test_day_wrap_down;
    test_mode12;
    test_set_fields;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
